// File: rtl/bus_controller_pkg.sv
// Shared definitions for the external bus controller and the CPU-side bus.
//   state_t        : controller FSM states
//   BYTES_PER_WORD : byte lanes in one CPU word
//   request_t      : one CPU word request (write flag, address, data, lane mask)
//   next_lane      : finds the lowest set mask bit at or above a starting lane
package bus_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
  } request_t;

  // Returns {none_found, lane}. start may be 4 (past the last lane), in which
  // case nothing is found. Scanning downward leaves the lowest match in r.
  function automatic logic [2:0] next_lane(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b100;
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= start)) r = {1'b0, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/external_bus_controller.sv
// Sequences 32-bit CPU word requests onto an 8-bit external bus.
// A read is four byte beats; a write is one beat per enabled byte lane.
// Every beat is one SETUP cycle followed by WAIT_CYCLES+1 STROBE cycles.
//
// Ports:
//   clock, reset            : system clock, asynchronous active-high reset
//   request_*               : CPU request channel (valid/ready handshake)
//   response_valid          : one-cycle completion pulse
//   response_read_data      : assembled read word, valid with response_valid
//   bus_address             : external byte address
//   bus_write_enable        : external write strobe
//   bus_write_data          : external write byte
//   bus_read_data           : external read byte
//   bus_output_enable       : pin direction, all ones while driving write data
//   debug_state             : current FSM state, for observation only
//
// Handshake: a request transfers on a rising clock edge where request_valid
// and request_ready are both 1. request_ready is 1 only in IDLE outside reset;
// the CPU must hold request_valid and the request fields stable until then.
module external_bus_controller
  import bus_controller_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH = 8,  // must be >= 3
  parameter int WAIT_CYCLES       = 0   // 0..15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         request_valid,
  output logic                         request_ready,
  input  logic                         request_write,
  input  logic [31:0]                  request_address,
  input  logic [31:0]                  request_write_data,
  input  logic [3:0]                   request_byte_enable,
  output logic                         response_valid,
  output logic [31:0]                  response_read_data,
  output logic [BUS_ADDRESS_WIDTH-1:0] bus_address,
  output logic                         bus_write_enable,
  output logic [7:0]                   bus_write_data,
  input  logic [7:0]                   bus_read_data,
  output logic [7:0]                   bus_output_enable,
  output state_t                       debug_state
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  request_t    req;
  logic [1:0]  index;
  logic [3:0]  wait_count;
  logic [31:0] read_lanes;

  request_t    incoming;
  request_t    setup_req;
  logic [1:0]  setup_index;
  logic [2:0]  first_write_lane;
  logic [2:0]  next_write_lane;
  logic        has_next;
  logic [1:0]  next_index;
  logic [31:0] read_word;

  // Only the bus-visible slice of the latched address is ever driven out.
  logic unused_address_bits;
  assign unused_address_bits = ^req.address;

  assign request_ready = (state == IDLE) && !reset;
  assign debug_state   = state;

  always_comb begin
    incoming = '{write:       request_write,
                 address:     request_address,
                 write_data:  request_write_data,
                 byte_enable: request_byte_enable};

    first_write_lane = next_lane(request_byte_enable, 3'd0);
    next_write_lane  = next_lane(req.byte_enable, {1'b0, index} + 3'd1);

    has_next   = req.write ? !next_write_lane[2] : (index != 2'd3);
    next_index = req.write ? next_write_lane[1:0] : index + 2'd1;

    // The beat about to be set up comes from the incoming request when
    // leaving IDLE, otherwise from the latched request.
    setup_req   = (state == IDLE) ? incoming : req;
    setup_index = (state == IDLE) ? (request_write ? first_write_lane[1:0] : 2'd0)
                                  : next_index;

    // Read word with the byte on the bus dropped into the current lane; this
    // is what gets captured at the final strobe edge of a read beat.
    read_word = read_lanes;
    read_word[{index, 3'b000} +: 8] = bus_read_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      req                <= '0;
      index              <= 2'd0;
      wait_count         <= 4'd0;
      read_lanes         <= 32'd0;
      response_valid     <= 1'b0;
      response_read_data <= 32'd0;
      bus_address        <= '0;
      bus_write_enable   <= 1'b0;
      bus_write_data     <= 8'd0;
      bus_output_enable  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (request_valid) begin
            req        <= incoming;
            read_lanes <= 32'd0;
            if (request_write && (request_byte_enable == 4'b0000)) begin
              // Nothing to put on the bus: complete straight away.
              state          <= RESPOND;
              response_valid <= 1'b1;
            end else begin
              state             <= SETUP;
              index             <= setup_index;
              wait_count        <= 4'd0;
              bus_address       <= {setup_req.address[BUS_ADDRESS_WIDTH-1:2], setup_index};
              bus_write_data    <= setup_req.write ? setup_req.write_data[{setup_index, 3'b000} +: 8]
                                                   : bus_write_data;
              bus_output_enable <= setup_req.write ? 8'hFF : 8'h00;
            end
          end
        end

        SETUP: begin
          state            <= STROBE;
          wait_count       <= 4'd0;
          bus_write_enable <= req.write;
        end

        STROBE: begin
          if (wait_count == WAIT_LAST) begin
            // Strobe drops on the same edge that moves on, so it is never
            // high during the following SETUP or RESPOND cycle.
            bus_write_enable <= 1'b0;
            if (!req.write) read_lanes <= read_word;
            if (has_next) begin
              state             <= SETUP;
              index             <= setup_index;
              wait_count        <= 4'd0;
              bus_address       <= {setup_req.address[BUS_ADDRESS_WIDTH-1:2], setup_index};
              bus_write_data    <= setup_req.write ? setup_req.write_data[{setup_index, 3'b000} +: 8]
                                                   : bus_write_data;
              bus_output_enable <= setup_req.write ? 8'hFF : 8'h00;
            end else begin
              state             <= RESPOND;
              response_valid    <= 1'b1;
              bus_output_enable <= 8'h00;
              if (!req.write) response_read_data <= read_word;
            end
          end else begin
            wait_count <= wait_count + 4'd1;
          end
        end

        RESPOND: begin
          state             <= IDLE;
          response_valid    <= 1'b0;
          bus_write_enable  <= 1'b0;
          bus_output_enable <= 8'h00;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_external_bus_controller.sv
// Bench for external_bus_controller: two instances (WAIT_CYCLES 0 and 3) share
// the request inputs and one external byte memory; outputs are muxed by sel.
module tb_external_bus_controller;
  import bus_controller_pkg::*;

  localparam int AW     = 8;
  localparam int W_FAST = 0;
  localparam int W_SLOW = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic        sel = 1'b0;
  logic        request_valid = 1'b0;
  logic        request_write = 1'b0;
  logic [31:0] request_address = '0;
  logic [31:0] request_write_data = '0;
  logic [3:0]  request_byte_enable = '0;
  logic [7:0]  bus_read_data = '0;

  logic [1:0]        valid_d, ready_d, rv_d, we_d;
  logic [1:0][31:0]  rdata_d;
  logic [1:0][AW-1:0] addr_d;
  logic [1:0][7:0]   wd_d, oe_d;
  state_t            dbg_d [2];

  assign valid_d[0] = request_valid && !sel;
  assign valid_d[1] = request_valid && sel;

  logic          ready, rv, we;
  logic [31:0]   rdata;
  logic [AW-1:0] addr_o;
  logic [7:0]    wd_o, oe_o;
  state_t        dbg;
  assign ready  = ready_d[sel];
  assign rv     = rv_d[sel];
  assign we     = we_d[sel];
  assign rdata  = rdata_d[sel];
  assign addr_o = addr_d[sel];
  assign wd_o   = wd_d[sel];
  assign oe_o   = oe_d[sel];
  assign dbg    = dbg_d[sel];

  external_bus_controller #(.BUS_ADDRESS_WIDTH(AW), .WAIT_CYCLES(W_FAST)) dut_fast (
    .clock(clock), .reset(reset),
    .request_valid(valid_d[0]), .request_ready(ready_d[0]),
    .request_write(request_write), .request_address(request_address),
    .request_write_data(request_write_data), .request_byte_enable(request_byte_enable),
    .response_valid(rv_d[0]), .response_read_data(rdata_d[0]),
    .bus_address(addr_d[0]), .bus_write_enable(we_d[0]), .bus_write_data(wd_d[0]),
    .bus_read_data(bus_read_data), .bus_output_enable(oe_d[0]), .debug_state(dbg_d[0])
  );

  external_bus_controller #(.BUS_ADDRESS_WIDTH(AW), .WAIT_CYCLES(W_SLOW)) dut_slow (
    .clock(clock), .reset(reset),
    .request_valid(valid_d[1]), .request_ready(ready_d[1]),
    .request_write(request_write), .request_address(request_address),
    .request_write_data(request_write_data), .request_byte_enable(request_byte_enable),
    .response_valid(rv_d[1]), .response_read_data(rdata_d[1]),
    .bus_address(addr_d[1]), .bus_write_enable(we_d[1]), .bus_write_data(wd_d[1]),
    .bus_read_data(bus_read_data), .bus_output_enable(oe_d[1]), .debug_state(dbg_d[1])
  );

  // ---------------- models ----------------
  logic [7:0]  bus_mem [256];  // external device, written by DUT strobes
  logic [7:0]  ref_mem [256];  // reference memory, updated from request semantics
  logic [31:0] last_rd [2];    // response_read_data each DUT should be holding

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic s, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int exp_lat, input int exp_beats, input logic [31:0] exp_rd);
    int wc, n, lat, beats_seen, k, pos, lane;
    logic [1:0] lanes [$];
    logic prev_we;
    logic [AW-1:0] ba;
    wc = s ? W_SLOW : W_FAST;
    for (int i = 0; i < 4; i++) if (!wr || be[i]) lanes.push_back(2'(i));
    n = lanes.size();

    @(negedge clock);
    sel = s; request_valid = 1'b1; request_write = wr;
    request_address = addr; request_write_data = wd; request_byte_enable = be;
    #1;
    check("ready_idle", 32'(ready), 32'd1);
    @(posedge clock); #1;
    request_valid = 1'b0;

    lat = 0; beats_seen = 0; prev_we = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (c > 1) begin @(posedge clock); #1; end
      check("ready_busy", 32'(ready), 32'd0);
      if (rv) lat = c;
      k   = (c - 1) / (wc + 2);
      pos = (c - 1) % (wc + 2);
      if (c <= n * (wc + 2)) begin
        lane = int'(lanes[k]);
        ba = {addr[AW-1:2], lanes[k]};
        check("bus_address", 32'(addr_o), 32'(ba));
        check("write_enable", 32'(we), 32'(wr && pos != 0));
        check("output_enable", 32'(oe_o), wr ? 32'hFF : 32'h00);
        if (wr && pos != 0) check("write_data", 32'(wd_o), 32'(wd[lane*8 +: 8]));
      end else begin
        check("write_enable_idle", 32'(we), 32'd0);
        check("output_enable_idle", 32'(oe_o), 32'd0);
      end
      if (we) bus_mem[addr_o] = wd_o;
      if (we && !prev_we) beats_seen++;
      prev_we = we;
      // Only the last strobe cycle of a beat carries real data.
      bus_read_data = (pos == wc + 1) ? bus_mem[addr_o] : 8'($urandom_range(0, 255));
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("beats", 32'(beats_seen), 32'(exp_beats));
    check("read_data", rdata, exp_rd);
    last_rd[s] = exp_rd;

    @(posedge clock); #1;
    check("response_pulse_end", 32'(rv), 32'd0);
    check("ready_after", 32'(ready), 32'd1);
  endtask

  // Reference: expected results straight from the request rules.
  task automatic model_txn(input logic s, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    int n, wc;
    logic [31:0] exp;
    logic [7:0] base;
    wc = s ? W_SLOW : W_FAST;
    base = {addr[7:2], 2'b00};
    if (wr) begin
      n = $countones(be);
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[base + 8'(i)] = wd[i*8 +: 8];
      exp = last_rd[s];
      run_txn(s, wr, addr, wd, be, n * (wc + 2) + 1, n, exp);
    end else begin
      exp = {ref_mem[base + 8'd3], ref_mem[base + 8'd2], ref_mem[base + 8'd1], ref_mem[base]};
      run_txn(s, wr, addr, wd, be, 4 * (wc + 2) + 1, 0, exp);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        s;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          lat;
    int          beats;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    last_rd[0] = '0;
    last_rd[1] = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 9,  0, 32'h4948_4B4A};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 4'b1111, 9,  4, 32'h4948_4B4A};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1122_3344, 4'b1010, 5,  2, 32'h4948_4B4A};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0030, 32'h5555_5555, 4'b0000, 1,  0, 32'h4948_4B4A};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 21, 0, 32'h4948_4B4A};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'b0000, 9,  0, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FF0A, 32'h0,         4'b1111, 9,  0, 32'h1150_3352};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0026, 32'h00AA_0000, 4'b0100, 6,  1, 32'h4948_4B4A};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,         4'b0000, 21, 0, 32'hDEAA_BEEF};

    // Reset state.
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_response_valid", 32'(rv), 32'd0);
    check("rst_read_data", rdata, 32'd0);
    check("rst_bus_address", 32'(addr_o), 32'd0);
    check("rst_output_enable", 32'(oe_o), 32'd0);
    check("rst_state", 32'(dbg), 32'(IDLE));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr)
        for (int j = 0; j < 4; j++)
          if (vecs[i].be[j]) ref_mem[{vecs[i].addr[7:2], 2'(j)}] = vecs[i].wd[j*8 +: 8];
      run_txn(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be,
              vecs[i].lat, vecs[i].beats, vecs[i].rd);
    end

    // Reset during the strobe of the second write beat.
    @(negedge clock);
    sel = 1'b0; request_valid = 1'b1; request_write = 1'b1;
    request_address = 32'h40; request_write_data = 32'hCAFE_F00D; request_byte_enable = 4'b1111;
    @(posedge clock); #1;
    request_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("mid_strobe_we", 32'(we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_we", 32'(we), 32'd0);
    check("abort_oe", 32'(oe_o), 32'd0);
    check("abort_address", 32'(addr_o), 32'd0);
    check("abort_write_data", 32'(wd_o), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_state", 32'(dbg), 32'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("abort_no_response", 32'(rv), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_abort", 32'(ready), 32'd1);
    last_rd[0] = '0;
    last_rd[1] = '0;
    run_txn(1'b0, 1'b0, 32'h40, 32'h0, 4'b0000, 9, 0, 32'h1918_1B1A);

    // Random traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      model_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                $urandom, 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/external_bus_controller.md
Name: external_bus_controller

Overview:
- Sequences the CPU's 32-bit word memory requests onto the narrow 8-bit external bus that goes out through the top-level pins.
- A read becomes four byte beats; a write becomes one beat per enabled byte.
- Each beat is timed with a setup phase and a programmable strobe phase.
- Sits between `cpu` and the top-level pin mapping, which also drives the bidirectional pin output-enable.

Parameters:
- BUS_ADDRESS_WIDTH, 8: external address width; must be ≥3.
- WAIT_CYCLES, 0: extra strobe cycles per beat, 0..15.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- request_valid, input, 1: CPU request present.
- request_ready, output, 1: controller accepts the request this cycle.
- request_write, input, 1: 1 = write, 0 = read.
- request_address, input, 32: byte address; bits [1:0] are ignored (word-aligned).
- request_write_data, input, 32: write word, little-endian lanes.
- request_byte_enable, input, 4: write lane mask; ignored for reads.
- response_valid, output, 1: one-cycle completion pulse.
- response_read_data, output, 32: assembled read word; valid with response_valid.
- bus_address, output, BUS_ADDRESS_WIDTH: external byte address.
- bus_write_enable, output, 1: external write strobe.
- bus_write_data, output, 8: external write byte.
- bus_read_data, input, 8: external read byte.
- bus_output_enable, output, 8: pin direction; all ones while driving write data.

Behaviour:
- Reset values, applied immediately on reset assertion regardless of clock: state IDLE; request_ready 0; response_valid 0; response_read_data 0; bus_address 0; bus_write_enable 0; bus_write_data 0; bus_output_enable 0; beat index 0; wait counter 0.
- Reset mid-transfer aborts the transfer with no response. A write strobe drops asynchronously.
- States: IDLE, SETUP, STROBE, RESPOND.
- IDLE:
  - request_ready = 1 (0 while reset is high).
  - On request_valid && request_ready, latch write, address, data and mask.
  - Read: beat index = 0, go to SETUP.
  - Write: beat index = lowest set mask bit, go to SETUP.
  - Write with mask 0000: go directly to RESPOND; no bus activity.
- SETUP (exactly 1 cycle):
  - bus_address = {latched_address[BUS_ADDRESS_WIDTH-1:2], index[1:0]}; upper address bits are truncated.
  - Write: bus_write_data = latched lane[index]; bus_output_enable = 8'hFF; bus_write_enable = 0.
  - Wait counter cleared. Go to STROBE.
- STROBE (WAIT_CYCLES+1 cycles):
  - Address, data and output enable held stable.
  - bus_write_enable = 1 for writes, 0 for reads.
  - Counter increments each cycle.
  - The beat ends in the cycle where counter == WAIT_CYCLES. On that cycle, a read captures bus_read_data into lane[index] at the clock edge.
  - Next beat: reads use index+1; writes use the next set mask bit above index.
  - If a next beat exists, go to SETUP; otherwise go to RESPOND.
- RESPOND (1 cycle):
  - response_valid = 1.
  - response_read_data = assembled word for reads; holds its previous value for writes.
  - bus_write_enable = 0; bus_output_enable = 0. Go to IDLE.
- bus_write_enable is never high during a SETUP cycle, so address and data changes never overlap the strobe.
- bus_output_enable is 0 in every read state and in IDLE.
- Latency, accept edge to response_valid:
  - read = 4·(WAIT_CYCLES+2)+1 cycles;
  - write = n·(WAIT_CYCLES+2)+1 cycles, where n = popcount(mask).
- request_valid while busy: ignored (ready = 0); the CPU must hold the request.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows RESPOND.

Decomposition:
- Shared package bus_controller_pkg:
  - state enum (IDLE, SETUP, STROBE, RESPOND);
  - BYTES_PER_WORD = 4;
  - request struct (write, address, write_data, byte_enable) reused by the cpu bus interface.
- No sub-module; the beat timer and lane selection stay inline.

Test Plan:
- Read 0x0000_0010, WAIT_CYCLES=0, bus model returns address ^ 0x5A:
  - bus_address sequence 0x10, 0x11, 0x12, 0x13, two cycles each;
  - response_valid 9 cycles after accept, data 0x4948_4B4A;
  - bus_output_enable stays 0.
- Write 0xDEAD_BEEF to 0x24, mask 1111:
  - strobes at 0x24/EF, 0x25/BE, 0x26/AD, 0x27/DE;
  - bus_output_enable = FF during beats;
  - write strobe never high during SETUP;
  - response after 9 cycles.
- Write mask 1010, data 0x1122_3344 to 0x08:
  - only 0x09/33 and 0x0B/11 strobed;
  - response after 5 cycles.
- Write mask 0000: no bus activity; response_valid the cycle after accept.
- WAIT_CYCLES=3 read:
  - each beat lasts 5 cycles; sampling only on the 5th;
  - bus data changed on earlier strobe cycles is ignored;
  - response at cycle 21.
- Reset asserted during the STROBE phase of write beat 2:
  - all outputs go to 0 the same cycle;
  - no response_valid;
  - after release, request_ready = 1 and a new read completes correctly.
